// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks active-low columns, debounces the first
// low row it finds, emits one key code per press and waits for a clean release.
`timescale 1ns/1ps

module keypad_scanner #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [7:0] button,
    output logic       key_held,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(DEBOUNCE_CNT - 1);

    state_t        state_q;
    logic [1:0]    col_q;
    logic [1:0]    row_q;
    logic [PW-1:0] per_cnt_q;
    logic [SW-1:0] stab_cnt_q;
    logic [7:0]    button_q;
    logic          key_held_q;
    logic [3:0]    row_s1_q;
    logic [3:0]    row_s2_q;

    logic          sample_pt;
    logic          any_low;
    logic          row_low;
    logic [1:0]    low_idx;
    logic [7:0]    code;

    // Row lines are asynchronous to clk; nothing below looks at row_n directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= row_n;
            row_s2_q <= row_s1_q;
        end
    end

    assign sample_pt = (per_cnt_q == PER_LAST);
    assign any_low   = ~&row_s2_q;
    assign row_low   = ~row_s2_q[row_q];
    assign code      = {2'b00, col_q, 4'd4 + {2'b00, row_q}};

    always_comb begin
        low_idx = 2'd3;
        if (!row_s2_q[0])      low_idx = 2'd0;
        else if (!row_s2_q[1]) low_idx = 2'd1;
        else if (!row_s2_q[2]) low_idx = 2'd2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SCAN;
            col_q      <= 2'd0;
            row_q      <= 2'd0;
            per_cnt_q  <= '0;
            stab_cnt_q <= '0;
            button_q   <= 8'h00;
            key_held_q <= 1'b0;
        end else begin
            button_q  <= 8'h00;
            per_cnt_q <= sample_pt ? '0 : per_cnt_q + 1'b1;
            case (state_q)
                SCAN: begin
                    if (sample_pt) begin
                        if (any_low) begin
                            row_q      <= low_idx;
                            stab_cnt_q <= '0;
                            per_cnt_q  <= '0;
                            state_q    <= DEBOUNCE;
                        end else begin
                            col_q <= col_q + 2'd1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (sample_pt) begin
                        if (row_low) begin
                            if (stab_cnt_q == STAB_LAST) begin
                                // Output registers load here so they are live during EMIT.
                                button_q   <= code;
                                key_held_q <= 1'b1;
                                per_cnt_q  <= '0;
                                state_q    <= EMIT;
                            end else begin
                                stab_cnt_q <= stab_cnt_q + 1'b1;
                            end
                        end else begin
                            col_q     <= col_q + 2'd1;
                            per_cnt_q <= '0;
                            state_q   <= SCAN;
                        end
                    end
                end
                EMIT: begin
                    stab_cnt_q <= '0;
                    per_cnt_q  <= '0;
                    state_q    <= RELEASE;
                end
                RELEASE: begin
                    if (sample_pt) begin
                        if (!row_low) begin
                            if (stab_cnt_q == STAB_LAST) begin
                                col_q      <= col_q + 2'd1;
                                key_held_q <= 1'b0;
                                per_cnt_q  <= '0;
                                state_q    <= SCAN;
                            end else begin
                                stab_cnt_q <= stab_cnt_q + 1'b1;
                            end
                        end else begin
                            stab_cnt_q <= '0;
                        end
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign col_n     = ~(4'b0001 << col_q);
    assign button    = button_q;
    assign key_held  = key_held_q;
    assign state_dbg = state_q;

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: number of clk cycles in each column dwell and sample period, minimum 2.
REQ-002 Parameter DEBOUNCE_CNT, default 4: number of consecutive agreeing samples needed to accept a press or a release, minimum 1.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port row_n, input, 4 bits: keypad row sense lines, active-low, asynchronous to clk.
REQ-006 Port col_n, output, 4 bits: keypad column drive, active-low, one-hot-low.
REQ-007 Port button, output, 8 bits: key code, valid for exactly one cycle per accepted press, 8'h00 otherwise.
REQ-008 Port key_held, output, 1 bit: high from the emit cycle until the release is accepted.

Function
REQ-009 row_n SHALL pass through a 2-flop synchroniser (reset value 4'hF) before any use; "sample" below means the synchronised value.
REQ-010 Key code SHALL be {4-bit column index c, 4'd4 + row index r}, c and r in 0..3; e.g. c=1,r=0 gives 8'h14 (zero), c=0,r=1 gives 8'h05 (one), c=2,r=0 gives 8'h24 (equal), c=3,r=3 gives 8'h37 (add).
REQ-011 FSM states: SCAN, DEBOUNCE, EMIT, RELEASE.
REQ-012 A period counter SHALL count 0..SCAN_DIV-1 and wrap; the "sample point" is the cycle where it equals SCAN_DIV-1; it clears to 0 on every state change.
REQ-013 SCAN: drive col_n = ~(4'b1 << c). At the sample point with any row low, capture r (lowest low row index wins), clear the stable count and enter DEBOUNCE; otherwise advance c (3 wraps to 0).
REQ-014 DEBOUNCE: hold the column. At each sample point, if row r is low, increment the stable count. When the count reaches DEBOUNCE_CNT, enter EMIT. If row r is high, return to SCAN with c advanced.
REQ-015 EMIT: one cycle, button = code, key_held = 1, then enter RELEASE with the stable count cleared.
REQ-016 RELEASE: hold the column and keep button = 8'h00. At each sample point, row r high increments the stable count and row r low clears it. When the count reaches DEBOUNCE_CNT, enter SCAN with c advanced and key_held = 0.
REQ-017 Other keys pressed while in DEBOUNCE, EMIT or RELEASE SHALL be ignored; only the captured row of the held column is examined.
REQ-018 Holding a key SHALL emit exactly one code, with no auto-repeat.
REQ-019 Press-to-emit latency SHALL be at most 4*SCAN_DIV (scan reaching the column) + DEBOUNCE_CNT*SCAN_DIV + 3 cycles (synchroniser plus state entry).
REQ-020 The stable-count width SHALL hold DEBOUNCE_CNT; the period-counter width SHALL hold SCAN_DIV-1; neither counter may overflow.
REQ-021 button SHALL never carry a code outside the 16 defined values or 8'h00.

Reset
REQ-022 While rst is high, and immediately on its assertion: state = SCAN, c = 0, col_n = 4'b1110, button = 8'h00, key_held = 0, all counters = 0, synchroniser = 4'hF.
REQ-023 Reset asserted in any state, including mid-debounce or with a key held, SHALL abort with no code emitted. After release, a key still held SHALL be re-debounced and emitted once.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-024 Single press: hold c=1,r=0 until key_held, then release -> exactly one button=8'h14 pulse; key_held falls 3 sample periods after release.
REQ-025 Bounce: c=2,r=3 toggled every 5 cycles for 40 cycles, then held stable -> no emit during bouncing, then one 8'h27.
REQ-026 Multi-key: c=0 rows 1 and 2 pressed together -> 8'h05 only; releasing row 2 alone produces no new code.
REQ-027 Long hold: c=3,r=3 held for 500 cycles -> single 8'h37; col_n stays 4'b0111 throughout.
REQ-028 Column walk: no key pressed -> col_n sequence 1110, 1101, 1011, 0111, 1110, each held for 4 cycles.
REQ-029 Reset mid-debounce: rst pulsed after 1 accepted sample of c=0,r=0 -> button stays 8'h00 and col_n = 1110; the held key then yields one 8'h04.
